// File: rtl/conv2d_stream_engine.sv
// Streaming KxK 2-D convolution over an SRAM-resident image with shift-and-saturate output.
// Build option: define RELU_EN to clamp negative results to zero before saturation.
module conv2d_stream_engine #(
   parameter int KERNEL_SIZE = 3,
   parameter int DATA_WIDTH  = 8,
   parameter int ACC_WIDTH   = 20,
   parameter int IMG_W       = 8,
   parameter int IMG_H       = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int KADDR_WIDTH = 6,
   parameter int SHIFT       = 0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   output logic [ADDR_WIDTH-1:0]  o_img_addr,
   input  logic [DATA_WIDTH-1:0]  i_img_data,
   output logic [KADDR_WIDTH-1:0] o_kernel_addr,
   input  logic [DATA_WIDTH-1:0]  i_kernel_data,
   output logic [DATA_WIDTH-1:0]  o_result,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic                   o_busy,
   output logic                   o_done
);

   localparam int KK  = KERNEL_SIZE * KERNEL_SIZE;
   localparam int CW  = $clog2(KK + 1);
   localparam int KXW = $clog2(KERNEL_SIZE + 1);
   localparam int XW  = $clog2(IMG_W + 1);
   localparam int YW  = $clog2(IMG_H + 1);
   localparam int PW  = 2 * DATA_WIDTH;

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_OUTPUT, S_DONE} state_t;

   state_t                        r_state;
   logic [CW-1:0]                 r_cnt;
   logic [KXW-1:0]                r_kx;
   logic [XW-1:0]                 r_ox;
   logic [YW-1:0]                 r_oy;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic signed [DATA_WIDTH-1:0]  r_tap [0:(1<<CW)-1];

   logic [CW-1:0]                 w_tidx;
   logic signed [PW-1:0]          w_pix_x;
   logic signed [PW-1:0]          w_tap_x;
   logic signed [PW-1:0]          w_prod;
   logic signed [ACC_WIDTH-1:0]   w_acc_nxt;
   logic                          w_last_x;
   logic                          w_last_y;
   logic [XW-1:0]                 w_ox_nxt;
   logic [YW-1:0]                 w_oy_nxt;

   function automatic logic signed [DATA_WIDTH-1:0] sat_fn(input logic signed [ACC_WIDTH-1:0] a);
      logic signed [ACC_WIDTH-1:0] s;
      s = a >>> SHIFT;
`ifdef RELU_EN
      if (s < 0) s = '0;
`else
`endif
      if (s > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
      else if (s < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
      else                  return s[DATA_WIDTH-1:0];
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] base_fn(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return ADDR_WIDTH'(int'(y) * IMG_W + int'(x));
   endfunction

   // Data for the address issued last cycle arrives now, so taps/products lag r_cnt by one.
   assign w_tidx    = r_cnt - 1'b1;
   assign w_pix_x   = {{DATA_WIDTH{i_img_data[DATA_WIDTH-1]}}, i_img_data};
   assign w_tap_x   = {{DATA_WIDTH{r_tap[w_tidx][DATA_WIDTH-1]}}, r_tap[w_tidx]};
   assign w_prod    = w_pix_x * w_tap_x;
   assign w_acc_nxt = r_acc + ACC_WIDTH'(w_prod);

   assign w_last_x  = (r_ox == XW'(IMG_W - KERNEL_SIZE));
   assign w_last_y  = (r_oy == YW'(IMG_H - KERNEL_SIZE));
   assign w_ox_nxt  = w_last_x ? '0 : r_ox + 1'b1;
   assign w_oy_nxt  = w_last_x ? r_oy + 1'b1 : r_oy;

   always_ff @(posedge i_clk) begin
      if (r_state == S_LOAD && r_cnt != '0)
         r_tap[w_tidx] <= i_kernel_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_kx          <= '0;
         r_ox          <= '0;
         r_oy          <= '0;
         r_acc         <= '0;
         o_img_addr    <= '0;
         o_kernel_addr <= '0;
         o_result      <= '0;
         o_valid       <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  r_state       <= S_LOAD;
                  o_busy        <= 1'b1;
                  r_ox          <= '0;
                  r_oy          <= '0;
                  r_cnt         <= '0;
                  o_kernel_addr <= '0;
               end
            end
            S_LOAD: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt < CW'(KK - 1))
                  o_kernel_addr <= KADDR_WIDTH'(r_cnt) + 1'b1;
               if (r_cnt == CW'(KK)) begin
                  r_state    <= S_MAC;
                  r_cnt      <= '0;
                  r_kx       <= '0;
                  r_acc      <= '0;
                  o_img_addr <= base_fn(r_ox, r_oy);
               end
            end
            S_MAC: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt != '0)
                  r_acc <= w_acc_nxt;
               // Walk the window raster: step by one, jump to the next image row at kx wrap.
               if (r_cnt < CW'(KK - 1)) begin
                  if (r_kx == KXW'(KERNEL_SIZE - 1)) begin
                     r_kx       <= '0;
                     o_img_addr <= o_img_addr + ADDR_WIDTH'(IMG_W - KERNEL_SIZE + 1);
                  end else begin
                     r_kx       <= r_kx + 1'b1;
                     o_img_addr <= o_img_addr + 1'b1;
                  end
               end
               if (r_cnt == CW'(KK)) begin
                  r_state  <= S_OUTPUT;
                  o_result <= sat_fn(w_acc_nxt);
                  o_valid  <= 1'b1;
               end
            end
            S_OUTPUT: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  r_ox    <= w_ox_nxt;
                  r_oy    <= w_oy_nxt;
                  if (w_last_x && w_last_y) begin
                     r_state <= S_DONE;
                     o_done  <= 1'b1;
                  end else begin
                     r_state    <= S_MAC;
                     r_cnt      <= '0;
                     r_kx       <= '0;
                     r_acc      <= '0;
                     o_img_addr <= base_fn(w_ox_nxt, w_oy_nxt);
                  end
               end
            end
            S_DONE: begin
               o_done  <= 1'b0;
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Bench for conv2d_stream_engine: two instances (SHIFT=0 and SHIFT=2) on a 4x4 image, K=3,
// table of image/kernel patterns with expected result streams checked through a scoreboard.
module tb_conv2d_stream_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, ready;
   logic [7:0] addr1, addr2, img_q1, img_q2, ker_q1, ker_q2, res1, res2;
   logic [5:0] kaddr1, kaddr2;
   logic       vld1, vld2, busy1, busy2, done1, done2;

   logic [7:0] img_mem [16];
   logic [7:0] ker_mem [16];

   typedef struct {
      int img_mode;
      int kmode;
      int kval;
      int exp0 [4];
      int exp2 [4];
   } vec_t;

   vec_t tbl [6];
   int   q1 [$];
   int   q2 [$];
   int   n_vec = 0;
   int   n_fail = 0;

   conv2d_stream_engine #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .ACC_WIDTH(20), .IMG_W(4), .IMG_H(4),
                          .ADDR_WIDTH(8), .KADDR_WIDTH(6), .SHIFT(0)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .o_img_addr(addr1), .i_img_data(img_q1),
      .o_kernel_addr(kaddr1), .i_kernel_data(ker_q1), .o_result(res1), .o_valid(vld1),
      .i_ready(ready), .o_busy(busy1), .o_done(done1));

   conv2d_stream_engine #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .ACC_WIDTH(20), .IMG_W(4), .IMG_H(4),
                          .ADDR_WIDTH(8), .KADDR_WIDTH(6), .SHIFT(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .o_img_addr(addr2), .i_img_data(img_q2),
      .o_kernel_addr(kaddr2), .i_kernel_data(ker_q2), .o_result(res2), .o_valid(vld2),
      .i_ready(ready), .o_busy(busy2), .o_done(done2));

   always @(posedge clk) begin
      img_q1 <= img_mem[addr1[3:0]];
      img_q2 <= img_mem[addr2[3:0]];
      ker_q1 <= ker_mem[kaddr1[3:0]];
      ker_q2 <= ker_mem[kaddr2[3:0]];
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input int im, input int km, input int kv,
                          input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3);
      tbl[i].img_mode = im;
      tbl[i].kmode    = km;
      tbl[i].kval     = kv;
      tbl[i].exp0[0] = a0; tbl[i].exp0[1] = a1; tbl[i].exp0[2] = a2; tbl[i].exp0[3] = a3;
      tbl[i].exp2[0] = b0; tbl[i].exp2[1] = b1; tbl[i].exp2[2] = b2; tbl[i].exp2[3] = b3;
   endtask

   function automatic int relu_adj(input int v);
`ifdef RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_img_addr"}, int'(addr1), 0);
      chk({tag, "_kernel_addr"}, int'(kaddr1), 0);
      chk({tag, "_result"}, int'(res1), 0);
      chk({tag, "_valid"}, int'(vld1), 0);
      chk({tag, "_busy"}, int'(busy1), 0);
      chk({tag, "_done"}, int'(done1), 0);
   endtask

   task automatic run_pass(input int vi, input bit bp, input bit sdb, input bit abort);
      int  nres, hs_e, e, rsav, asav;
      bit  first_seen, stalled, finished;
      for (int i = 0; i < 16; i++)
         img_mem[i] = (tbl[vi].img_mode == 0) ? 8'(i + 1) : 8'(100);
      for (int i = 0; i < 16; i++) begin
         if (tbl[vi].kmode == 0) ker_mem[i] = (i < 9) ? 8'(tbl[vi].kval) : 8'(0);
         else                    ker_mem[i] = (i == tbl[vi].kval) ? 8'(1) : 8'(0);
      end
      for (int j = 0; j < 4; j++) begin
         q1.push_back(relu_adj(tbl[vi].exp0[j]));
         q2.push_back(relu_adj(tbl[vi].exp2[j]));
      end
      nres = 0; hs_e = -1; first_seen = 0; stalled = 0; finished = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", int'(busy1), 1);
      chk("kaddr_after_start", int'(kaddr1), 0);
      e = 0;
      while (e < 1000 && !finished) begin
         @(negedge clk);
         if (vld1 && !first_seen) begin
            first_seen = 1;
            chk("first_valid_cycle", e, 20);
         end
         if (sdb) start = (e == 30 || e == 31);
         if (bp && vld1 && nres == 1 && !stalled) begin
            stalled = 1;
            ready = 1'b0;
            rsav = int'($signed(res1));
            asav = int'(addr1);
            chk("stall_result", rsav, tbl[vi].exp0[1]);
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               e++;
               chk("stall_valid", int'(vld1), 1);
               chk("stall_result_stable", int'($signed(res1)), rsav);
               chk("stall_addr_stable", int'(addr1), asav);
            end
            ready = 1'b1;
         end
         if (abort && nres == 2 && e == hs_e + 3) begin
            rst = 1'b1;
            #1;
            chk_all_zero("abort");
            q1.delete();
            q2.delete();
            @(negedge clk);
            rst = 1'b0;
            for (int s = 0; s < 4; s++) begin
               @(negedge clk);
               chk("abort_no_done", int'(done1), 0);
               chk("abort_idle", int'(busy1), 0);
            end
            finished = 1;
         end else begin
            if (vld1 && ready) begin
               if (q1.size() == 0 || q2.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_result: got %0d, expected no result", int'($signed(res1)));
               end else begin
                  chk($sformatf("v%0d_sh0_res%0d", vi, nres), int'($signed(res1)), q1.pop_front());
                  chk($sformatf("v%0d_sh2_res%0d", vi, nres), int'($signed(res2)), q2.pop_front());
               end
               nres++;
               hs_e = e + 1;
            end
            if (done1) begin
               chk("done_after_last_hs", e, hs_e);
               chk("result_count", nres, 4);
               chk("queue_drained", q1.size(), 0);
               start = 1'b1;
               @(negedge clk);
               chk("busy_falls_after_done", int'(busy1), 0);
               chk("done_one_cycle", int'(done1), 0);
               start = 1'b0;
               @(negedge clk);
               chk("start_on_done_ignored", int'(busy1), 0);
               finished = 1;
            end
         end
         e++;
      end
      if (!finished) begin
         n_vec++;
         n_fail++;
         $display("FAIL pass%0d_timeout: got no o_done, expected o_done within 1000 cycles", vi);
         q1.delete();
         q2.delete();
      end
   endtask

   initial begin
      set_vec(0, 0, 0,  1,   54,   63,   90,   99,   13,   15,   22,   24);
      set_vec(1, 1, 0,  1,  127,  127,  127,  127,  127,  127,  127,  127);
      set_vec(2, 1, 0, -1, -128, -128, -128, -128, -128, -128, -128, -128);
      set_vec(3, 0, 0, -1,  -54,  -63,  -90,  -99,  -14,  -16,  -23,  -25);
      set_vec(4, 0, 1,  2,    3,    4,    7,    8,    0,    1,    1,    2);
      set_vec(5, 0, 1,  6,    9,   10,   13,   14,    2,    2,    3,    3);
      for (int i = 0; i < 16; i++) begin
         img_mem[i] = 8'(0);
         ker_mem[i] = 8'(0);
      end
      rst = 1'b1;
      start = 1'b0;
      ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      for (int vi = 0; vi < 6; vi++)
         run_pass(vi, vi == 0, vi == 1, 1'b0);
      run_pass(0, 1'b0, 1'b0, 1'b1);
      run_pass(0, 1'b0, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
